// File: rtl/lc3b_pkg.sv
// LC-3b shared definitions: opcodes, condition-code encoding, instruction field slices.
package lc3b_pkg;

  localparam int unsigned DataWidth = 16;
  localparam int          NumRegs   = 8;

  typedef logic [DataWidth-1:0] word_t;
  typedef logic [2:0]           reg_idx_t;
  typedef logic [2:0]           cc_t;
  typedef logic [3:0]           opcode_t;
  typedef logic [1:0]           sb_cnt_t;

  localparam sb_cnt_t SbCntMax = 2'd3;

  localparam opcode_t OpBr   = 4'h0;
  localparam opcode_t OpAdd  = 4'h1;
  localparam opcode_t OpLdb  = 4'h2;
  localparam opcode_t OpStb  = 4'h3;
  localparam opcode_t OpJsr  = 4'h4;
  localparam opcode_t OpAnd  = 4'h5;
  localparam opcode_t OpLdw  = 4'h6;
  localparam opcode_t OpStw  = 4'h7;
  localparam opcode_t OpRti  = 4'h8;
  localparam opcode_t OpXor  = 4'h9;
  localparam opcode_t OpJmp  = 4'hC;
  localparam opcode_t OpShf  = 4'hD;
  localparam opcode_t OpLea  = 4'hE;
  localparam opcode_t OpTrap = 4'hF;

  // Condition codes as {n, z, p}
  localparam cc_t CcN = 3'b100;
  localparam cc_t CcZ = 3'b010;
  localparam cc_t CcP = 3'b001;

  localparam int unsigned OpMsb      = 15;
  localparam int unsigned OpLsb      = 12;
  localparam int unsigned DrMsb      = 11;
  localparam int unsigned DrLsb      = 9;
  localparam int unsigned Sr1Msb     = 8;
  localparam int unsigned Sr1Lsb     = 6;
  localparam int unsigned Sr2Msb     = 2;
  localparam int unsigned Sr2Lsb     = 0;
  localparam int unsigned ImmSelBit  = 5;
  localparam int unsigned JsrModeBit = 11;

  localparam reg_idx_t LinkReg = 3'd7;

  function automatic opcode_t ir_opcode(input word_t ir);
    return ir[OpMsb:OpLsb];
  endfunction

  function automatic reg_idx_t ir_dr(input word_t ir);
    return ir[DrMsb:DrLsb];
  endfunction

  function automatic reg_idx_t ir_sr1(input word_t ir);
    return ir[Sr1Msb:Sr1Lsb];
  endfunction

  function automatic reg_idx_t ir_sr2(input word_t ir);
    return ir[Sr2Msb:Sr2Lsb];
  endfunction

  function automatic cc_t cc_of(input word_t data);
    if (data[DataWidth-1]) return CcN;
    else if (data == '0)   return CcZ;
    else                   return CcP;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// DE-latch input, writeback and AGEX-latch bundle between fetch, decode and execute.
interface decode_stage_if import lc3b_pkg::*; ();

  logic     de_v;
  word_t    de_npc;
  word_t    de_ir;
  logic     mem_stall;
  logic     sr_wb_en;
  reg_idx_t sr_wb_dr;
  word_t    sr_wb_data;
  logic     sr_ld_cc;

  logic     dep_stall;
  logic     v_de_br_stall;
  logic     agex_v;
  word_t    agex_npc;
  word_t    agex_ir;
  word_t    agex_sr1;
  word_t    agex_sr2;
  cc_t      agex_cc;
  reg_idx_t agex_dr;
  logic     agex_ld_reg;
  logic     agex_ld_cc;

  modport master (
    output de_v, de_npc, de_ir, mem_stall, sr_wb_en, sr_wb_dr, sr_wb_data, sr_ld_cc,
    input  dep_stall, v_de_br_stall, agex_v, agex_npc, agex_ir, agex_sr1, agex_sr2,
    input  agex_cc, agex_dr, agex_ld_reg, agex_ld_cc
  );

  modport slave (
    input  de_v, de_npc, de_ir, mem_stall, sr_wb_en, sr_wb_dr, sr_wb_data, sr_ld_cc,
    output dep_stall, v_de_br_stall, agex_v, agex_npc, agex_ir, agex_sr1, agex_sr2,
    output agex_cc, agex_dr, agex_ld_reg, agex_ld_cc
  );

endinterface

// File: rtl/reg_file.sv
// 8x16 register file: two async read ports, one write port, write-before-read forwarding.
module reg_file import lc3b_pkg::*; (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     we,
  input  reg_idx_t waddr,
  input  word_t    wdata,
  input  reg_idx_t raddr_a,
  output word_t    rdata_a,
  input  reg_idx_t raddr_b,
  output word_t    rdata_b
);

  word_t regs [NumRegs];

  // Storage write; async reset clears every register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumRegs; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  // Reads see a same-cycle write to the same index
  always_comb begin
    rdata_a = (we && (waddr == raddr_a)) ? wdata : regs[raddr_a];
    rdata_b = (we && (waddr == raddr_b)) ? wdata : regs[raddr_b];
  end

endmodule

// File: rtl/decode_stage.sv
// LC-3b decode stage: field decode, register/CC scoreboard, CC register and AGEX latch.
module decode_stage import lc3b_pkg::*; (
  input logic           clk,
  input logic           rst_n,
  decode_stage_if.slave bus
);

  opcode_t      opcode;
  reg_idx_t     sr1_idx, sr2_idx, dr_idx;
  logic         use_sr1, use_sr2, use_cc, ld_reg, ld_cc, is_ctrl;
  word_t        sr1_data, sr2_data;
  cc_t          cc_q, cc_fwd;
  sb_cnt_t      reg_cnt [NumRegs];
  sb_cnt_t      cc_cnt;
  logic [NumRegs-1:0] reg_inc, reg_dec;
  logic         cc_inc, cc_dec, issue;
  logic         sr1_busy, sr2_busy, cc_busy, dep_stall;

  // A count of 1 that retires this very cycle no longer blocks the reader
  function automatic logic cnt_busy(input sb_cnt_t cnt, input logic retiring);
    return (cnt != 2'd0) && !((cnt == 2'd1) && retiring);
  endfunction

  // Saturating in-flight count; simultaneous inc and dec cancel
  function automatic sb_cnt_t cnt_next(input sb_cnt_t cnt, input logic inc, input logic dec);
    if (inc && !dec && (cnt != SbCntMax)) return cnt + 2'd1;
    if (dec && !inc && (cnt != 2'd0))     return cnt - 2'd1;
    return cnt;
  endfunction

  reg_file u_reg_file (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (bus.sr_wb_en),
    .waddr   (bus.sr_wb_dr),
    .wdata   (bus.sr_wb_data),
    .raddr_a (sr1_idx),
    .rdata_a (sr1_data),
    .raddr_b (sr2_idx),
    .rdata_b (sr2_data)
  );

  // Operand usage and destination per opcode
  always_comb begin
    opcode  = ir_opcode(bus.de_ir);
    sr1_idx = ir_sr1(bus.de_ir);
    sr2_idx = ir_sr2(bus.de_ir);
    dr_idx  = ir_dr(bus.de_ir);
    use_sr1 = 1'b0;
    use_sr2 = 1'b0;
    use_cc  = 1'b0;
    ld_reg  = 1'b0;
    ld_cc   = 1'b0;
    is_ctrl = 1'b0;
    case (opcode)
      OpAdd, OpAnd, OpXor: begin
        use_sr1 = 1'b1;
        use_sr2 = !bus.de_ir[ImmSelBit];
        ld_reg  = 1'b1;
        ld_cc   = 1'b1;
      end
      OpLdb, OpLdw, OpShf: begin
        use_sr1 = 1'b1;
        ld_reg  = 1'b1;
        ld_cc   = 1'b1;
      end
      OpStb, OpStw: begin
        use_sr1 = 1'b1;
        use_sr2 = 1'b1;
        sr2_idx = ir_dr(bus.de_ir);  // store data register sits in the DR field
      end
      OpLea: ld_reg = 1'b1;
      OpBr: begin
        use_cc  = 1'b1;
        is_ctrl = 1'b1;
      end
      OpJmp: begin
        use_sr1 = 1'b1;
        is_ctrl = 1'b1;
      end
      OpJsr: begin
        use_sr1 = !bus.de_ir[JsrModeBit];  // JSRR form reads a base register
        ld_reg  = 1'b1;
        dr_idx  = LinkReg;
        is_ctrl = 1'b1;
      end
      OpTrap: begin
        ld_reg  = 1'b1;
        dr_idx  = LinkReg;
        is_ctrl = 1'b1;
      end
      OpRti:   is_ctrl = 1'b1;
      default: ;
    endcase
  end

  // Dependency check, issue and per-counter inc/dec requests
  always_comb begin
    sr1_busy  = use_sr1 && cnt_busy(reg_cnt[sr1_idx],
                                    bus.sr_wb_en && (bus.sr_wb_dr == sr1_idx));
    sr2_busy  = use_sr2 && cnt_busy(reg_cnt[sr2_idx],
                                    bus.sr_wb_en && (bus.sr_wb_dr == sr2_idx));
    cc_busy   = use_cc && cnt_busy(cc_cnt, bus.sr_ld_cc);
    dep_stall = bus.de_v && (sr1_busy || sr2_busy || cc_busy);
    issue     = bus.de_v && !dep_stall && !bus.mem_stall;
    for (int i = 0; i < NumRegs; i++) begin
      reg_inc[i] = issue && ld_reg && (dr_idx == reg_idx_t'(i));
      reg_dec[i] = bus.sr_wb_en && (bus.sr_wb_dr == reg_idx_t'(i));
    end
    cc_inc = issue && ld_cc;
    cc_dec = bus.sr_ld_cc;
    cc_fwd = bus.sr_ld_cc ? cc_of(bus.sr_wb_data) : cc_q;
  end

  assign bus.dep_stall     = dep_stall;
  assign bus.v_de_br_stall = bus.de_v && is_ctrl;

  // Scoreboard counters; over/underflow saturates and is flagged in simulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumRegs; i++) reg_cnt[i] <= '0;
      cc_cnt <= '0;
    end else begin
      for (int i = 0; i < NumRegs; i++) begin
        assert (!(reg_inc[i] && !reg_dec[i] && (reg_cnt[i] == SbCntMax)))
          else $error("scoreboard overflow on R%0d", i);
        assert (!(reg_dec[i] && !reg_inc[i] && (reg_cnt[i] == 2'd0)))
          else $error("scoreboard underflow on R%0d", i);
        reg_cnt[i] <= cnt_next(reg_cnt[i], reg_inc[i], reg_dec[i]);
      end
      assert (!(cc_inc && !cc_dec && (cc_cnt == SbCntMax))) else $error("CC count overflow");
      assert (!(cc_dec && !cc_inc && (cc_cnt == 2'd0)))     else $error("CC count underflow");
      cc_cnt <= cnt_next(cc_cnt, cc_inc, cc_dec);
    end
  end

  // Architectural condition codes, loaded from writeback data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_q <= CcZ;
    end else if (bus.sr_ld_cc) begin
      cc_q <= cc_of(bus.sr_wb_data);
    end
  end

  // AGEX latch; frozen while memory stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.agex_v      <= 1'b0;
      bus.agex_npc    <= '0;
      bus.agex_ir     <= '0;
      bus.agex_sr1    <= '0;
      bus.agex_sr2    <= '0;
      bus.agex_cc     <= '0;
      bus.agex_dr     <= '0;
      bus.agex_ld_reg <= 1'b0;
      bus.agex_ld_cc  <= 1'b0;
    end else if (!bus.mem_stall) begin
      bus.agex_v      <= bus.de_v && !dep_stall;
      bus.agex_npc    <= bus.de_npc;
      bus.agex_ir     <= bus.de_ir;
      bus.agex_sr1    <= sr1_data;
      bus.agex_sr2    <= sr2_data;
      bus.agex_cc     <= cc_fwd;
      bus.agex_dr     <= dr_idx;
      bus.agex_ld_reg <= ld_reg;
      bus.agex_ld_cc  <= ld_cc;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized traffic vs a model.
module tb_decode_stage;
  import lc3b_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  decode_stage_if bus ();

  decode_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    bit u1, u2, ucc, lr, lc, br;
    int s1, s2, dr;
  } dec_t;

  logic [15:0] m_regs [8];
  logic [2:0]  m_cc;
  int          m_cnt [8];
  int          m_cc_cnt;

  logic        e_v, e_lr, e_lc, e_use1, e_use2;
  logic [15:0] e_npc, e_ir, e_sr1, e_sr2;
  logic [2:0]  e_cc, e_dr;

  function automatic dec_t model_decode(input logic [15:0] ir);
    dec_t d;
    int op;
    bit alu, ld, st;
    op    = int'(ir[15:12]);
    alu   = (op == 1) || (op == 5) || (op == 9);
    ld    = (op == 2) || (op == 6);
    st    = (op == 3) || (op == 7);
    d.u1  = alu || ld || st || (op == 13) || (op == 12) || ((op == 4) && !ir[11]);
    d.s1  = int'(ir[8:6]);
    d.u2  = (alu && !ir[5]) || st;
    d.s2  = st ? int'(ir[11:9]) : int'(ir[2:0]);
    d.ucc = (op == 0);
    d.lr  = alu || ld || (op == 14) || (op == 13) || (op == 4) || (op == 15);
    d.dr  = ((op == 4) || (op == 15)) ? 7 : int'(ir[11:9]);
    d.lc  = alu || ld || (op == 13);
    d.br  = (op == 0) || (op == 12) || (op == 4) || (op == 15) || (op == 8);
    return d;
  endfunction

  function automatic logic [2:0] model_nzp(input logic [15:0] v);
    if (v[15]) return 3'b100;
    if (v == 16'h0000) return 3'b010;
    return 3'b001;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      m_regs[i] = 16'h0000;
      m_cnt[i]  = 0;
    end
    m_cc = 3'b010; m_cc_cnt = 0;
    e_v = 0; e_lr = 0; e_lc = 0; e_use1 = 0; e_use2 = 0;
    e_npc = 0; e_ir = 0; e_sr1 = 0; e_sr2 = 0; e_cc = 0; e_dr = 0;
  endfunction

  // Busy means still in flight after whatever retires this cycle
  function automatic bit model_dep_stall();
    dec_t d;
    int r1, r2, rc;
    d  = model_decode(bus.de_ir);
    r1 = (bus.sr_wb_en && (int'(bus.sr_wb_dr) == d.s1)) ? 1 : 0;
    r2 = (bus.sr_wb_en && (int'(bus.sr_wb_dr) == d.s2)) ? 1 : 0;
    rc = bus.sr_ld_cc ? 1 : 0;
    if (!bus.de_v) return 0;
    return (d.u1 && (m_cnt[d.s1] - r1 > 0)) || (d.u2 && (m_cnt[d.s2] - r2 > 0)) ||
           (d.ucc && (m_cc_cnt - rc > 0));
  endfunction

  function automatic logic [15:0] model_read(input int idx);
    if (bus.sr_wb_en && (int'(bus.sr_wb_dr) == idx)) return bus.sr_wb_data;
    return m_regs[idx];
  endfunction

  function automatic void model_step();
    dec_t d;
    bit stall, issue;
    if (!rst_n) begin
      model_reset();
      return;
    end
    d     = model_decode(bus.de_ir);
    stall = model_dep_stall();
    issue = bus.de_v && !stall && !bus.mem_stall;
    if (!bus.mem_stall) begin
      e_v    = bus.de_v && !stall;
      e_npc  = bus.de_npc;
      e_ir   = bus.de_ir;
      e_sr1  = model_read(d.s1);
      e_sr2  = model_read(d.s2);
      e_cc   = bus.sr_ld_cc ? model_nzp(bus.sr_wb_data) : m_cc;
      e_dr   = d.dr[2:0];
      e_lr   = d.lr;
      e_lc   = d.lc;
      e_use1 = d.u1;
      e_use2 = d.u2;
    end
    if (issue && d.lr) m_cnt[d.dr]++;
    if (issue && d.lc) m_cc_cnt++;
    if (bus.sr_wb_en) begin
      m_cnt[bus.sr_wb_dr]--;
      m_regs[bus.sr_wb_dr] = bus.sr_wb_data;
    end
    if (bus.sr_ld_cc) begin
      m_cc_cnt--;
      m_cc = model_nzp(bus.sr_wb_data);
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.de_v = 0; bus.de_npc = 0; bus.de_ir = 0; bus.mem_stall = 0;
    bus.sr_wb_en = 0; bus.sr_wb_dr = 0; bus.sr_wb_data = 0; bus.sr_ld_cc = 0;
  endtask

  task automatic drive_de(input logic [15:0] ir, input logic [15:0] npc);
    bus.de_v = 1; bus.de_ir = ir; bus.de_npc = npc;
  endtask

  task automatic drive_wb(input logic [2:0] dr, input logic [15:0] data, input logic ldcc);
    bus.sr_wb_en = 1; bus.sr_wb_dr = dr; bus.sr_wb_data = data; bus.sr_ld_cc = ldcc;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    set_idle();
    rst_n = 0;
    drive_wb(3'd2, 16'hBEEF, 1'b1);  // must be ignored while in reset
    model_reset();
    #3;
    checks++; if (bus.agex_v !== 1'b0) begin failures++; $display("FAIL reset_agex_v: got %b want 0", bus.agex_v); end
    checks++; if (bus.agex_ir !== 16'h0) begin failures++; $display("FAIL reset_agex_ir: got %h want 0000", bus.agex_ir); end
    checks++; if (bus.agex_cc !== 3'b000) begin failures++; $display("FAIL reset_agex_cc: got %b want 000", bus.agex_cc); end
    checks++; if ({bus.dep_stall, bus.v_de_br_stall} !== 2'b00) begin failures++; $display("FAIL reset_stalls: got %b want 00", {bus.dep_stall, bus.v_de_br_stall}); end
    tick();
    set_idle();
    rst_n = 1;
    tick();
  endtask

  task automatic test_add_issue();
    drive_de(16'h1042, 16'h3002);  // ADD R0,R1,R2
    #1;
    checks++; if (bus.dep_stall !== 1'b0) begin failures++; $display("FAIL add_dep_stall: got %b want 0", bus.dep_stall); end
    tick();
    checks++; if (bus.agex_v !== 1'b1) begin failures++; $display("FAIL add_agex_v: got %b want 1", bus.agex_v); end
    checks++; if (bus.agex_dr !== 3'd0) begin failures++; $display("FAIL add_agex_dr: got %0d want 0", bus.agex_dr); end
    checks++; if ({bus.agex_ld_reg, bus.agex_ld_cc} !== 2'b11) begin failures++; $display("FAIL add_ld_flags: got %b want 11", {bus.agex_ld_reg, bus.agex_ld_cc}); end
    checks++; if (bus.agex_npc !== 16'h3002) begin failures++; $display("FAIL add_agex_npc: got %h want 3002", bus.agex_npc); end
    checks++; if (bus.agex_sr2 !== 16'h0000) begin failures++; $display("FAIL add_sr2_reset_wb_ignored: got %h want 0000", bus.agex_sr2); end
    checks++; if (bus.agex_cc !== 3'b010) begin failures++; $display("FAIL add_cc_after_reset: got %b want 010", bus.agex_cc); end
  endtask

  task automatic test_raw_forward();
    drive_de(16'h1200, 16'h3004);  // ADD R1,R0,R0 while R0 in flight
    #1;
    checks++; if (bus.dep_stall !== 1'b1) begin failures++; $display("FAIL raw_dep_stall: got %b want 1", bus.dep_stall); end
    tick();
    checks++; if (bus.agex_v !== 1'b0) begin failures++; $display("FAIL raw_bubble: got agex_v=%b want 0", bus.agex_v); end
    drive_wb(3'd0, 16'h0005, 1'b1);
    #1;
    checks++; if (bus.dep_stall !== 1'b0) begin failures++; $display("FAIL raw_wb_release: got %b want 0", bus.dep_stall); end
    tick();
    checks++; if (bus.agex_v !== 1'b1) begin failures++; $display("FAIL raw_issue_v: got %b want 1", bus.agex_v); end
    checks++; if (bus.agex_sr1 !== 16'h0005) begin failures++; $display("FAIL raw_fwd_sr1: got %h want 0005", bus.agex_sr1); end
    checks++; if (bus.agex_sr2 !== 16'h0005) begin failures++; $display("FAIL raw_fwd_sr2: got %h want 0005", bus.agex_sr2); end
    set_idle();
    drive_wb(3'd1, 16'h0000, 1'b1);  // retire ADD R1
    tick();
    set_idle();
  endtask

  task automatic test_branch();
    set_idle();
    rst_n = 0;
    model_reset();
    tick();
    rst_n = 1;
    drive_de(16'h0402, 16'h4000);  // BRz
    #1;
    checks++; if (bus.v_de_br_stall !== 1'b1) begin failures++; $display("FAIL br_ctrl_stall: got %b want 1", bus.v_de_br_stall); end
    checks++; if (bus.dep_stall !== 1'b0) begin failures++; $display("FAIL br_dep_stall: got %b want 0", bus.dep_stall); end
    tick();
    checks++; if (bus.agex_cc !== 3'b010) begin failures++; $display("FAIL br_agex_cc: got %b want 010", bus.agex_cc); end
    checks++; if (bus.agex_v !== 1'b1) begin failures++; $display("FAIL br_agex_v: got %b want 1", bus.agex_v); end
    bus.de_ir = 16'h1042;
    #1;
    checks++; if (bus.v_de_br_stall !== 1'b0) begin failures++; $display("FAIL alu_not_ctrl: got %b want 0", bus.v_de_br_stall); end
    bus.de_ir = 16'hC1C0; bus.de_v = 0;  // JMP R7 but not valid
    #1;
    checks++; if (bus.v_de_br_stall !== 1'b0) begin failures++; $display("FAIL invalid_ctrl: got %b want 0", bus.v_de_br_stall); end
    bus.de_v = 1;
    #1;
    checks++; if (bus.v_de_br_stall !== 1'b1) begin failures++; $display("FAIL jmp_ctrl: got %b want 1", bus.v_de_br_stall); end
    set_idle();
    tick();
  endtask

  task automatic test_mem_stall();
    drive_de(16'h1042, 16'h5002);  // ADD R0,R1,R2
    tick();
    bus.mem_stall = 1;
    drive_de(16'h1643, 16'h5004);  // ADD R3,R1,R3 held in DE
    drive_wb(3'd0, 16'h1234, 1'b1);
    for (int c = 0; c < 3; c++) begin
      tick();
      bus.sr_wb_en = 0; bus.sr_ld_cc = 0;
      checks++; if ({bus.agex_v, bus.agex_ir} !== {1'b1, 16'h1042}) begin failures++; $display("FAIL stall_hold cyc%0d: got v=%b ir=%h want v=1 ir=1042", c, bus.agex_v, bus.agex_ir); end
    end
    bus.mem_stall = 0;
    drive_de(16'h18C0, 16'h5006);  // ADD R4,R3,R0: R3 never issued, R0 retired
    #1;
    checks++; if (bus.dep_stall !== 1'b0) begin failures++; $display("FAIL stall_no_issue: got dep_stall=%b want 0", bus.dep_stall); end
    tick();
    checks++; if (bus.agex_ir !== 16'h18C0) begin failures++; $display("FAIL stall_release_ir: got %h want 18c0", bus.agex_ir); end
    checks++; if (bus.agex_sr2 !== 16'h1234) begin failures++; $display("FAIL stall_wb_written: got %h want 1234", bus.agex_sr2); end
    set_idle();
    drive_wb(3'd4, 16'h0001, 1'b1);
    tick();
    set_idle();
  endtask

  task automatic test_cc_wb();
    logic [15:0] data [2];
    logic [2:0]  want [2];
    data[0] = 16'h8000; want[0] = 3'b100;
    data[1] = 16'h0000; want[1] = 3'b010;
    for (int k = 0; k < 2; k++) begin
      set_idle();
      drive_de(16'h16C2, 16'h6000);  // ADD R3,R3,R2
      tick();
      drive_de(16'h0E00, 16'h6002);  // BRnzp, CC in flight
      #1;
      checks++; if (bus.dep_stall !== 1'b1) begin failures++; $display("FAIL cc_busy%0d: got %b want 1", k, bus.dep_stall); end
      tick();
      checks++; if (bus.agex_v !== 1'b0) begin failures++; $display("FAIL cc_bubble%0d: got %b want 0", k, bus.agex_v); end
      drive_wb(3'd3, data[k], 1'b1);
      #1;
      checks++; if (bus.dep_stall !== 1'b0) begin failures++; $display("FAIL cc_release%0d: got %b want 0", k, bus.dep_stall); end
      tick();
      checks++; if ({bus.agex_v, bus.agex_cc} !== {1'b1, want[k]}) begin failures++; $display("FAIL cc_fwd%0d: got v=%b cc=%b want v=1 cc=%b", k, bus.agex_v, bus.agex_cc, want[k]); end
    end
    set_idle();
  endtask

  task automatic test_async_reset();
    drive_de(16'h1042, 16'h7002);
    tick();
    set_idle();
    #2;
    rst_n = 0;
    model_reset();
    #1;
    checks++; if ({bus.agex_v, bus.agex_npc, bus.agex_ir, bus.agex_ld_reg} !== 34'h0) begin failures++; $display("FAIL async_clear: got v=%b npc=%h ir=%h ldr=%b want all 0", bus.agex_v, bus.agex_npc, bus.agex_ir, bus.agex_ld_reg); end
    checks++; if (bus.dep_stall !== 1'b0) begin failures++; $display("FAIL async_dep_stall: got %b want 0", bus.dep_stall); end
    #2;
    rst_n = 1;
    drive_de(16'h1200, 16'h7004);  // reads R0, in flight before reset
    #1;
    checks++; if (bus.dep_stall !== 1'b0) begin failures++; $display("FAIL async_sb_clear_r0: got %b want 0", bus.dep_stall); end
    bus.de_ir = 16'h0E00;
    #1;
    checks++; if (bus.dep_stall !== 1'b0) begin failures++; $display("FAIL async_sb_clear_cc: got %b want 0", bus.dep_stall); end
    tick();
    set_idle();
    tick();
  endtask

  task automatic test_random();
    int ops [14] = '{1, 5, 9, 2, 6, 3, 7, 13, 0, 4, 12, 14, 15, 8};
    dec_t d;
    bit exp_stall;
    logic [15:0] ir;
    int pick, idx;
    for (int n = 0; n < 400; n++) begin
      set_idle();
      if ($urandom_range(2) == 0) begin
        pick = int'($urandom_range(7));
        for (int k = 0; k < 8; k++) begin
          idx = (pick + k) % 8;
          if (!bus.sr_wb_en && m_cnt[idx] > 0) begin
            bus.sr_wb_en = 1; bus.sr_wb_dr = idx[2:0];
          end
        end
      end
      if (m_cc_cnt > 0 && $urandom_range(2) == 0) bus.sr_ld_cc = 1;
      case ($urandom_range(3))
        0:       bus.sr_wb_data = 16'h0000;
        1:       bus.sr_wb_data = 16'h8000 | 16'($urandom);
        default: bus.sr_wb_data = 16'($urandom);
      endcase
      bus.mem_stall = ($urandom_range(4) == 0);
      ir = 16'($urandom);
      ir[15:12] = 4'(ops[$urandom_range(13)]);
      bus.de_ir  = ir;
      bus.de_npc = 16'($urandom);
      bus.de_v   = ($urandom_range(3) != 0);
      d = model_decode(ir);
      if ((d.lr && m_cnt[d.dr] >= 3) || (d.lc && m_cc_cnt >= 3)) bus.de_v = 0;
      #1;
      exp_stall = model_dep_stall();
      checks++; if (bus.dep_stall !== exp_stall) begin failures++; $display("FAIL rand_dep_stall n=%0d ir=%h: got %b want %b", n, ir, bus.dep_stall, exp_stall); end
      checks++; if (bus.v_de_br_stall !== (bus.de_v && d.br)) begin failures++; $display("FAIL rand_br_stall n=%0d ir=%h: got %b want %b", n, ir, bus.v_de_br_stall, bus.de_v && d.br); end
      tick();
      checks++; if ({bus.agex_v, bus.agex_npc, bus.agex_ir} !== {e_v, e_npc, e_ir}) begin failures++; $display("FAIL rand_agex_hdr n=%0d: got v=%b npc=%h ir=%h want v=%b npc=%h ir=%h", n, bus.agex_v, bus.agex_npc, bus.agex_ir, e_v, e_npc, e_ir); end
      checks++; if ({bus.agex_cc, bus.agex_ld_reg, bus.agex_ld_cc} !== {e_cc, e_lr, e_lc}) begin failures++; $display("FAIL rand_agex_ctl n=%0d: got cc=%b ldr=%b ldcc=%b want cc=%b ldr=%b ldcc=%b", n, bus.agex_cc, bus.agex_ld_reg, bus.agex_ld_cc, e_cc, e_lr, e_lc); end
      if (e_use1) begin
        checks++; if (bus.agex_sr1 !== e_sr1) begin failures++; $display("FAIL rand_sr1 n=%0d: got %h want %h", n, bus.agex_sr1, e_sr1); end
      end
      if (e_use2) begin
        checks++; if (bus.agex_sr2 !== e_sr2) begin failures++; $display("FAIL rand_sr2 n=%0d: got %h want %h", n, bus.agex_sr2, e_sr2); end
      end
      if (e_lr) begin
        checks++; if (bus.agex_dr !== e_dr) begin failures++; $display("FAIL rand_dr n=%0d: got %0d want %0d", n, bus.agex_dr, e_dr); end
      end
    end
    set_idle();
  endtask

  initial begin
    test_reset();
    test_add_issue();
    test_raw_forward();
    test_branch();
    test_mem_stall();
    test_cc_wb();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
